timer_slot_scheduler: RTL

//   Shares one down-counting delay timer between NUM_REQ requesters using a round-robin arbiter.

---
 rtl/timer_slot_scheduler_pkg.sv | 15 +
 rtl/timer_slot_scheduler_rr_arbiter.sv | 46 ++++
 rtl/timer_slot_scheduler.sv | 103 ++++++++++
 3 files changed

// File: rtl/timer_slot_scheduler_pkg.sv
// Shared types and helpers for the round-robin timer slot scheduler.
package timer_slot_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index of the requester after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/timer_slot_scheduler_rr_arbiter.sv
// Round-robin one-hot picker: scans req upward from ptr with wrap-around.
// ptr moves to the slot after the finished owner when upd is strobed.
module timer_slot_scheduler_rr_arbiter
    import timer_slot_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd,
    input  logic [PTR_W-1:0]   upd_idx,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx
);

    logic [PTR_W-1:0] ptr;

    always_comb begin
        int  idx;
        logic found;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found         = 1'b1;
                pick[idx]     = 1'b1;
                pick_idx      = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= PTR_W'(wrap_inc(int'(upd_idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/timer_slot_scheduler.sv
// Shares one down-counting delay timer between NUM_REQ requesters; the
// granted requester's delay is counted on tick_en and done pulses on expiry.
module timer_slot_scheduler
    import timer_slot_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick_en,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] delay,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         remaining
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state;
    logic [PTR_W-1:0]   own_idx;
    logic [NUM_REQ-1:0] arb_pick;
    logic [PTR_W-1:0]   arb_idx;
    logic [CNT_W-1:0]   win_delay;
    logic               owner_req;
    logic               arb_upd;

    // Only the winner's delay is sampled, and only at grant time.
    always_comb begin
        win_delay = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_pick[i]) win_delay = delay[i*CNT_W +: CNT_W];
        end
    end

    assign owner_req = |(req & grant);
    assign arb_upd   = (state == ST_DONE) || ((state == ST_RUN) && !owner_req);

    timer_slot_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .upd      (arb_upd),
        .upd_idx  (own_idx),
        .pick     (arb_pick),
        .pick_idx (arb_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            remaining <= '0;
            own_idx   <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant     <= arb_pick;
                        own_idx   <= arb_idx;
                        remaining <= win_delay;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort takes priority over a coincident tick.
                    if (!owner_req) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if ((remaining == '0) ||
                                 (tick_en && (remaining == CNT_W'(1)))) begin
                        remaining <= '0;
                        done      <= grant;
                        state     <= ST_DONE;
                    end else if (tick_en) begin
                        remaining <= remaining - 1'b1;
                    end
                end
                ST_DONE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
